mod_updown_counter: RTL
=======================

Name: mod_updown_counter

Overview:
- Parametrised successor to the team's 5-bit loadable up-counter.
- Adds:
  - WIDTH generalisation
  - up/down direction
  - programmable terminal limit
  - wrap or saturate mode
  - enable prescaler
  - registered terminal-count pulse
  - sticky overflow flag
- Used as a general event/timer counter in control paths.
- Drop-in superset: with up=1, mode=wrap, limit=all-ones, presc=0, it behaves as the original counter.

Parameters:
- WIDTH, 5, count/data/limit width in bits (>=2).
- PRESC_W, 4, prescaler select width; enable is divided by (presc+1).
- RESET_VAL, 0, value of count after reset; must be <= all-ones of WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_  input  1  asynchronous active-low reset.
- data  input  WIDTH  parallel load value.
- load  input  1  synchronous load of data into count.
- enable  input  1  count-event qualifier, fed to the prescaler.
- up  input  1  direction: 1 = increment, 0 = decrement.
- mode  input  1  0 = wrap, 1 = saturate.
- limit  input  WIDTH  upper bound of the counting range 0..limit.
- presc  input  PRESC_W  prescale select; a step occurs every presc+1 enabled cycles.
- clear_ovf  input  1  clears the sticky ovf flag.
- count  output  WIDTH  current count, registered.
- tc  output  1  one-cycle terminal-count pulse, registered.
- ovf  output  1  sticky flag: a terminal step has occurred.
- zero  output  1  count == 0, decoded directly from the count register.

Behaviour:
- Reset:
  - Clock and reset: single clock clk; reset rst_ is asynchronous and active-low.
  - While rst_=0: count=RESET_VAL, tc=0, ovf=0, prescaler pcnt=0.
  - Reset mid-operation discards all state immediately, with no clock required.
- Priority per clock edge: rst_ > load > step.
- Load:
  - load=1: count<=data on the next edge; pcnt<=0.
  - No tc is generated and ovf is unchanged.
  - enable in the same cycle is ignored.
  - data>limit is accepted as-is.
- Prescaler:
  - pcnt counts enabled cycles.
  - step = enable && !load && (pcnt==presc).
  - On step, pcnt<=0; otherwise, if enable, pcnt<=pcnt+1.
  - presc=0 gives a step on every enabled cycle.
  - If presc changes mid-count and pcnt>presc, pcnt runs to all-ones, wraps to 0, then steps normally. No lock-up.
- Terminal condition, evaluated on step:
  - up=1: term = (count >= limit).
  - up=0: term = (count == 0).
- Step, non-terminal: count<=count+1 (up) or count-1 (down), modulo 2^WIDTH never reached.
- Step, terminal:
  - Wrap mode: up gives count<=0; down gives count<=limit.
  - Saturate mode: count holds its value.
  - Either mode: tc<=1 for exactly one cycle (the cycle after the edge), and ovf<=1.
- tc is 0 in every cycle not immediately following a terminal step.
- ovf:
  - Set by a terminal step; cleared by clear_ovf.
  - Set wins over clear when both occur on the same edge.
- limit=0: count is held at 0 in both modes; every step is terminal.
- Direction/mode/limit changes take effect on the next step; there is no pipeline.
- Latency: count, tc and ovf update one clock after the qualifying cycle. zero follows count combinationally.

Decomposition:
- Package mod_counter_pkg:
  - typedef enum logic {CNT_WRAP=1'b0, CNT_SAT=1'b1} cnt_mode_e.
  - localparam defaults for WIDTH and PRESC_W.
- Sub-module counter_prescaler:
  - Inputs: clk, rst_, enable, load (as clear), presc.
  - Output: step.
  - Holds pcnt.
- Top-level mod_updown_counter holds count/tc/ovf and the terminal and next-value logic.

Test Plan (WIDTH=5, RESET_VAL=0):
- Reset/legacy: assert rst_=0 mid-count at count=9 → count=0, tc=0, ovf=0 asynchronously. Then release with up=1, mode=wrap, limit=31, presc=0, enable=1 for 33 cycles → count runs 0..31, 0, 1; tc pulses once, the cycle count returns to 0; ovf=1.
- Limit wrap/saturate:
  - limit=5, up=1, wrap, enable continuous → 0,1,2,3,4,5,0,…; tc in the cycle count becomes 0.
  - Repeat with mode=sat → count holds 5; tc pulses on every further step.
- Down count: load data=2, up=0, wrap, limit=7 → 2,1,0,7,6; tc once.
  - Saturate variant → holds 0; zero=1 throughout.
- Prescaler: presc=2, enable=1 continuous from count=0 → count increments every 3rd cycle (0,0,0,1,1,1,2…).
  - Assert load (data=10) mid-phase → count=10; pcnt restarts, so the next increment comes 3 enabled cycles later.
- Priority/ovf:
  - load=1 with enable=1 at a terminal step → count=data, no tc, ovf unchanged.
  - clear_ovf=1 coincident with a terminal step → ovf stays 1.
  - clear_ovf alone → ovf=0.
- Out-of-range: limit=4, load data=20, up=1, wrap, step → count=0, tc=1.
  - Down step from 20 → 19, no tc.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the up/down event counter.
package mod_counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam int CNT_WIDTH   = 5;
  localparam int CNT_PRESC_W = 4;

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: one step every presc+1 enabled cycles.
module counter_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESC_W = CNT_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               step
);

  logic [PRESC_W-1:0] pcnt_q;
  logic [PRESC_W-1:0] pcnt_d;

  assign step = enable && !clear && (pcnt_q == presc);

  // pcnt above a shrunk presc simply runs round to 0
  always_comb begin
    pcnt_d = pcnt_q;
    if (clear || step) begin
      pcnt_d = '0;
    end else if (enable) begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Loadable up/down counter with limit, wrap/saturate,
// prescaled enable, terminal-count pulse and sticky overflow.
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int               WIDTH     = CNT_WIDTH,
  parameter int               PRESC_W   = CNT_PRESC_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [WIDTH-1:0]   data,
  input  logic               load,
  input  logic               enable,
  input  logic               up,
  input  logic               mode,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clear_ovf,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               ovf,
  output logic               zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             step;
  logic             term;
  cnt_mode_e        mode_e;

  assign mode_e = cnt_mode_e'(mode);

  counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk    (clk),
    .rst_   (rst_),
    .enable (enable),
    .clear  (load),
    .presc  (presc),
    .step   (step)
  );

  assign term = up ? (count_q >= limit)
                   : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clear_ovf) begin
      ovf_d = 1'b0;
    end
    if (load) begin
      count_d = data;
    end else if (step) begin
      if (!term) begin
        count_d = up ? count_q + WIDTH'(1)
                     : count_q - WIDTH'(1);
      end else begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (mode_e == CNT_WRAP) begin
          count_d = up ? '0 : limit;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign zero  = (count_q == '0);

endmodule
